// File: rtl/alu_operand_sequencer_pkg.sv
// rtl/alu_operand_sequencer_pkg.sv - shared types and display constants for the operand sequencer
package alu_operand_sequencer_pkg;

  // Operand-entry step, also drives the step indicator
  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    ISSUE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // ALU opcode encoding shared with the ALU datapath
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_t;

  // 7-segment patterns, bit7 = DP (always off); reused by the ALU result display
  localparam logic [7:0] SEG_A    = 8'b0111_0111;
  localparam logic [7:0] SEG_B    = 8'b0111_1100;
  localparam logic [7:0] SEG_O    = 8'b0101_1100;
  localparam logic [7:0] SEG_DASH = 8'b0100_0000;
  localparam logic [7:0] SEG_D    = 8'b0101_1110;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// rtl/alu_operand_sequencer_if.sv - switch inputs and ALU request handshake bundle
interface alu_operand_sequencer_if #(
  parameter int NBITS_OPND = 3,
  parameter int NBITS_OP   = 2
);
  logic [NBITS_OPND-1:0] data_in;
  logic [NBITS_OP-1:0]   op_in;
  logic                  load;
  logic                  clear;
  logic                  ready;
  logic [NBITS_OPND-1:0] a_out;
  logic [NBITS_OPND-1:0] b_out;
  logic [NBITS_OP-1:0]   op_out;
  logic                  valid;
  logic [7:0]            step_seg;

  // Operator panel / ALU side
  modport master (
    output data_in, op_in, load, clear, ready,
    input  a_out, b_out, op_out, valid, step_seg
  );

  // Sequencer side
  modport slave (
    input  data_in, op_in, load, clear, ready,
    output a_out, b_out, op_out, valid, step_seg
  );
endinterface

// File: rtl/alu_operand_sequencer_load_debouncer.sv
// rtl/alu_operand_sequencer_load_debouncer.sv - load switch debouncer with rise strobe
module load_debouncer #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk_2,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);
  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;

  // Count cycles of disagreement; accept the raw level once it has held long enough
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (i_raw != r_level) begin
        if (r_cnt == CNT_MAX) begin
          r_level <= i_raw;
          r_cnt   <= '0;
          r_rise  <= i_raw;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
endmodule

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - three-press operand entry FSM with valid/ready issue
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int NBITS_OPND      = 3,
  parameter int NBITS_OP        = 2
) (
  input logic                    clk_2,
  input logic                    reset,
  alu_operand_sequencer_if.slave bus
);
  state_t                r_state;
  state_t                w_next;
  logic [NBITS_OPND-1:0] r_a;
  logic [NBITS_OPND-1:0] r_b;
  logic [NBITS_OP-1:0]   r_op;
  logic                  w_load_db;
  logic                  w_rise;
  logic                  w_press;
  logic                  w_valid;
  logic [7:0]            w_seg;

  load_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load_debouncer (
    .clk_2  (clk_2),
    .reset  (reset),
    .i_raw  (bus.load),
    .o_level(w_load_db),
    .o_rise (w_rise)
  );

  // A press is the one-cycle rise of the debounced level
  assign w_press = w_rise & w_load_db;

  // State register
  always_ff @(posedge clk_2) begin
    if (reset) r_state <= GET_A;
    else       r_state <= w_next;
  end

  // Next state: clear beats press and ready; ready only matters in ISSUE
  always_comb begin
    w_next = r_state;
    if (bus.clear) begin
      w_next = GET_A;
    end else begin
      case (r_state)
        GET_A:   if (w_press)   w_next = GET_B;
        GET_B:   if (w_press)   w_next = GET_OP;
        GET_OP:  if (w_press)   w_next = ISSUE;
        ISSUE:   if (bus.ready) w_next = DONE;
        DONE:    if (w_press)   w_next = GET_B;
        default:                w_next = GET_A;
      endcase
    end
  end

  // Outputs decoded from the registered state, so valid is glitch-free
  always_comb begin
    w_valid = 1'b0;
    w_seg   = SEG_A;
    case (r_state)
      GET_A:   w_seg = SEG_A;
      GET_B:   w_seg = SEG_B;
      GET_OP:  w_seg = SEG_O;
      ISSUE: begin
        w_seg   = SEG_DASH;
        w_valid = 1'b1;
      end
      DONE:    w_seg = SEG_D;
      default: w_seg = SEG_A;
    endcase
  end

  // Field capture on a press; fields survive clear and are only overwritten by new presses
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else if (!bus.clear && w_press) begin
      case (r_state)
        GET_A, DONE: r_a  <= bus.data_in;
        GET_B:       r_b  <= bus.data_in;
        GET_OP:      r_op <= bus.op_in;
        default:     ;
      endcase
    end
  end

  assign bus.a_out    = r_a;
  assign bus.b_out    = r_b;
  assign bus.op_out   = r_op;
  assign bus.valid    = w_valid;
  assign bus.step_seg = w_seg;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - directed scoreboard bench for the operand sequencer
module tb_alu_operand_sequencer;
  import alu_operand_sequencer_pkg::*;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] op;
  } word_t;

  logic  clk;
  logic  rst;
  int    n_tests;
  int    n_fail;
  word_t exp_q[$];
  word_t exp_w;
  word_t obs_w;

  alu_operand_sequencer_if #(.NBITS_OPND(3), .NBITS_OP(2)) bus ();

  alu_operand_sequencer #(
    .DEBOUNCE_CYCLES(2),
    .NBITS_OPND     (3),
    .NBITS_OP       (2)
  ) dut (
    .clk_2(clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic word_t cur_word();
    word_t w;
    w.a  = bus.a_out;
    w.b  = bus.b_out;
    w.op = bus.op_out;
    return w;
  endfunction

  task automatic press(input logic [2:0] d, input logic [1:0] op);
    bus.data_in = d;
    bus.op_in   = op;
    bus.load    = 1'b1;
    repeat (6) @(negedge clk);
    bus.load = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic accept();
    check("valid_before_accept", 32'(bus.valid), 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      exp_w = exp_q.pop_front();
      obs_w = cur_word();
      check("accepted_word", 32'(obs_w), 32'(exp_w));
    end
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    check("valid_after_accept", 32'(bus.valid), 32'd0);
    check("seg_done", 32'(bus.step_seg), 32'(SEG_D));
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.data_in = '0;
    bus.op_in   = '0;
    bus.load    = 1'b0;
    bus.clear   = 1'b0;
    bus.ready   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_seg", 32'(bus.step_seg), 32'(SEG_A));
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_a", 32'(bus.a_out), 32'd0);
    check("rst_b", 32'(bus.b_out), 32'd0);
    check("rst_op", 32'(bus.op_out), 32'd0);

    // Glitches shorter than the debounce window never produce a press
    bus.data_in = 3'd6;
    for (int i = 0; i < 4; i++) begin
      bus.load = (i % 2 == 0);
      @(negedge clk);
    end
    bus.load = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_seg", 32'(bus.step_seg), 32'(SEG_A));
    check("glitch_a", 32'(bus.a_out), 32'd0);

    // Clean rise: strobe 3 cycles after the rise, capture on the following edge
    bus.data_in = 3'd5;
    bus.load    = 1'b1;
    repeat (3) @(negedge clk);
    check("latency_not_early", 32'(bus.step_seg), 32'(SEG_A));
    @(negedge clk);
    check("latency_seg_b", 32'(bus.step_seg), 32'(SEG_B));
    check("cap_a", 32'(bus.a_out), 32'd5);
    // Holding load for 50 cycles total yields exactly one capture
    bus.data_in = 3'd1;
    repeat (46) @(negedge clk);
    check("hold_seg_b", 32'(bus.step_seg), 32'(SEG_B));
    check("hold_b_untouched", 32'(bus.b_out), 32'd0);
    bus.load = 1'b0;
    repeat (4) @(negedge clk);

    // Operand B, with ready asserted outside ISSUE (ignored)
    bus.ready = 1'b1;
    press(3'd3, 2'b00);
    bus.ready = 1'b0;
    check("seg_o", 32'(bus.step_seg), 32'(SEG_O));
    check("cap_b", 32'(bus.b_out), 32'd3);
    check("valid_in_get_op", 32'(bus.valid), 32'd0);

    exp_q.push_back('{a: 3'd5, b: 3'd3, op: OP_ADD});
    press(3'd0, OP_ADD);
    check("seg_issue", 32'(bus.step_seg), 32'(SEG_DASH));
    check("valid_issue", 32'(bus.valid), 32'd1);

    // Outputs hold stable while waiting for ready
    for (int i = 0; i < 10; i++) begin
      obs_w = cur_word();
      check("hold_word", 32'(obs_w), 32'(exp_q[0]));
      check("hold_valid", 32'(bus.valid), 32'd1);
      @(negedge clk);
    end
    accept();

    // Press in DONE captures A and moves to GET_B; B and opcode kept
    press(3'd7, 2'b01);
    check("done_seg_b", 32'(bus.step_seg), 32'(SEG_B));
    check("done_cap_a", 32'(bus.a_out), 32'd7);
    check("done_keep_b", 32'(bus.b_out), 32'd3);
    check("done_keep_op", 32'(bus.op_out), 32'(OP_ADD));

    press(3'd1, 2'b00);
    exp_q.push_back('{a: 3'd7, b: 3'd1, op: OP_SUB});
    press(3'd0, OP_SUB);
    check("seg_issue2", 32'(bus.step_seg), 32'(SEG_DASH));

    // Clear together with ready aborts the transfer
    bus.clear = 1'b1;
    bus.ready = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.ready = 1'b0;
    check("abort_seg_a", 32'(bus.step_seg), 32'(SEG_A));
    check("abort_valid", 32'(bus.valid), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(bus.step_seg), 32'(SEG_A));
    obs_w = cur_word();
    check("abort_fields_kept", 32'(obs_w), 32'(exp_q[0]));
    void'(exp_q.pop_front());

    // Fresh full request after the abort
    press(3'd2, 2'b00);
    press(3'd4, 2'b00);
    exp_q.push_back('{a: 3'd2, b: 3'd4, op: OP_OR});
    press(3'd0, OP_OR);
    accept();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
